// File: rtl/cosim_run_ctrl.sv
// Run controller for the emulation top: staggered reset release, run-cycle
// counting, trace-dump window by cycle number and a commit watchdog.
module cosim_run_ctrl #(
  parameter int NUM_RESETS  = 4,
  parameter int RST_STAGGER = 8,
  parameter int CNT_WIDTH   = 64,
  parameter int WDOG_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CNT_WIDTH-1:0]  dump_start,
  input  logic [CNT_WIDTH-1:0]  dump_end,
  input  logic [WDOG_WIDTH-1:0] timeout,
  input  logic                  commit_valid,
  input  logic                  stop_req,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic [CNT_WIDTH-1:0]  cycle,
  output logic                  dump_active,
  output logic                  dump_on,
  output logic                  dump_off,
  output logic                  finish,
  output logic [1:0]            finish_code
);

  localparam int SEQ_LEN = NUM_RESETS * RST_STAGGER;
  localparam int SC_W    = $clog2(SEQ_LEN + 1);

  typedef enum logic [1:0] {SEQ, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [SC_W-1:0]       sc_reg, sc_next;
  logic [NUM_RESETS-1:0] rst_reg, rst_next;
  logic [CNT_WIDTH-1:0]  cycle_reg, cycle_next;
  logic [WDOG_WIDTH-1:0] idle_reg, idle_next;
  logic                  act_reg, act_next;
  logic                  on_reg, on_next;
  logic                  off_reg, off_next;
  logic                  fin_reg, fin_next;
  logic [1:0]            code_reg, code_next;

  logic [SC_W-1:0]       sc_inc;
  logic [NUM_RESETS-1:0] release_hit;
  logic [CNT_WIDTH-1:0]  cycle_inc;
  logic [WDOG_WIDTH:0]   idle_plus;
  logic [WDOG_WIDTH-1:0] idle_sat;
  logic                  wd_hit, de_hit, end_hit;

  assign sc_inc = sc_reg + SC_W'(1);

  // Domain gi leaves reset on the edge the stagger count reaches (gi+1)*RST_STAGGER.
  generate
    for (genvar gi = 0; gi < NUM_RESETS; gi++) begin : g_release
      assign release_hit[gi] = (sc_inc == SC_W'((gi + 1) * RST_STAGGER));
    end
  endgenerate

  assign cycle_inc = (&cycle_reg) ? cycle_reg : cycle_reg + CNT_WIDTH'(1);
  // One extra bit so the timeout compare never aliases on wrap.
  assign idle_plus = {1'b0, idle_reg} + (WDOG_WIDTH + 1)'(1);
  assign idle_sat  = (&idle_reg) ? idle_reg : idle_plus[WDOG_WIDTH-1:0];
  assign wd_hit    = (timeout != '0) && !commit_valid && (idle_plus == {1'b0, timeout});
  assign de_hit    = (dump_end != '0) && (cycle_inc == dump_end);
  assign end_hit   = wd_hit || de_hit || stop_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= SEQ;
      sc_reg    <= '0;
      rst_reg   <= '1;
      cycle_reg <= '0;
      idle_reg  <= '0;
      act_reg   <= 1'b0;
      on_reg    <= 1'b0;
      off_reg   <= 1'b0;
      fin_reg   <= 1'b0;
      code_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      sc_reg    <= sc_next;
      rst_reg   <= rst_next;
      cycle_reg <= cycle_next;
      idle_reg  <= idle_next;
      act_reg   <= act_next;
      on_reg    <= on_next;
      off_reg   <= off_next;
      fin_reg   <= fin_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sc_next    = sc_reg;
    rst_next   = rst_reg;
    cycle_next = cycle_reg;
    idle_next  = idle_reg;
    act_next   = act_reg;
    on_next    = 1'b0;
    off_next   = 1'b0;
    fin_next   = fin_reg;
    code_next  = code_reg;
    case (state_reg)
      SEQ: begin
        sc_next  = sc_inc;
        rst_next = rst_reg & ~release_hit;
        if (sc_inc == SC_W'(SEQ_LEN)) begin
          state_next = RUN;
          if (dump_start == '0) begin
            act_next = 1'b1;
            on_next  = 1'b1;
          end
        end
      end
      RUN: begin
        cycle_next = cycle_inc;
        idle_next  = commit_valid ? '0 : idle_sat;
        if (end_hit) begin
          state_next = DONE;
          fin_next   = 1'b1;
          code_next  = wd_hit ? 2'd2 : (de_hit ? 2'd1 : 2'd3);
          act_next   = 1'b0;
          off_next   = act_reg;
        end else if (!act_reg && (cycle_inc == dump_start)) begin
          act_next = 1'b1;
          on_next  = 1'b1;
        end
      end
      DONE: ;
      default: state_next = SEQ;
    endcase
  end

  assign rst_out     = rst_reg;
  assign cycle       = cycle_reg;
  assign dump_active = act_reg;
  assign dump_on     = on_reg;
  assign dump_off    = off_reg;
  assign finish      = fin_reg;
  assign finish_code = code_reg;

endmodule

// File: tb/tb_cosim_run_ctrl.sv
// Scoreboard bench for cosim_run_ctrl: a per-scenario reference model pushes
// expected per-edge outputs; a monitor pops and compares after every edge.
module tb_cosim_run_ctrl;
  localparam int NR = 3;
  localparam int RS = 4;
  localparam int CW = 16;
  localparam int WW = 8;
  localparam int T0 = NR * RS;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] dump_start = '0;
  logic [CW-1:0] dump_end = '0;
  logic [WW-1:0] timeout = '0;
  logic          commit_valid = 1'b0;
  logic          stop_req = 1'b0;
  logic [NR-1:0] rst_out;
  logic [CW-1:0] cycle;
  logic          dump_active, dump_on, dump_off, finish;
  logic [1:0]    finish_code;

  cosim_run_ctrl #(.NUM_RESETS(NR), .RST_STAGGER(RS), .CNT_WIDTH(CW), .WDOG_WIDTH(WW)) dut (
    .clock(clock), .reset(reset), .dump_start(dump_start), .dump_end(dump_end),
    .timeout(timeout), .commit_valid(commit_valid), .stop_req(stop_req),
    .rst_out(rst_out), .cycle(cycle), .dump_active(dump_active), .dump_on(dump_on),
    .dump_off(dump_off), .finish(finish), .finish_code(finish_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            edge_no;
    logic [NR-1:0] rst;
    int            cyc;
    bit            act, on, off, fin;
    int            code;
  } exp_t;

  exp_t  q[$];
  exp_t  mx;
  int    total = 0;
  int    bad = 0;
  string cur_name = "none";
  bit    cm[1:64];
  bit    st[1:64];
  int    klen, ds, de, to, kend, kcode;

  // Monitor: one comparison per edge the scoreboard has an entry for.
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset && q.size() > 0) begin
      mx = q.pop_front();
      total++;
      if (rst_out !== mx.rst || cycle !== CW'(mx.cyc) || dump_active !== mx.act ||
          dump_on !== mx.on || dump_off !== mx.off || finish !== mx.fin ||
          finish_code !== 2'(mx.code)) begin
        bad++;
        $display("FAIL %s edge%0d: got rst=%b cyc=%0d act=%b on=%b off=%b fin=%b code=%0d want rst=%b cyc=%0d act=%b on=%b off=%b fin=%b code=%0d",
                 cur_name, mx.edge_no, rst_out, cycle, dump_active, dump_on, dump_off, finish, finish_code,
                 mx.rst, mx.cyc, mx.act, mx.on, mx.off, mx.fin, mx.code);
      end else begin
        $display("ok   %s edge%0d rst=%b cyc=%0d act=%b on=%b off=%b fin=%b code=%0d",
                 cur_name, mx.edge_no, rst_out, cycle, dump_active, dump_on, dump_off, finish, finish_code);
      end
    end
  end

  // Reference: the run ends at the first RUN cycle k with a cause; idle length
  // at k is the distance back to the last commit (or to RUN entry).
  task automatic model_end();
    int lastc;
    bit wd, dh;
    lastc = 0;
    kend  = klen;
    kcode = 3;
    for (int k = 1; k <= klen; k++) begin
      wd = (to != 0) && !cm[k] && (k - lastc == to);
      dh = (de != 0) && (k == de);
      if (wd || dh || st[k]) begin
        kend  = k;
        kcode = wd ? 2 : (dh ? 1 : 3);
        break;
      end
      if (cm[k]) lastc = k;
    end
  endtask

  function automatic exp_t exp_at(int e);
    exp_t x;
    int   k;
    bit   opens;
    k     = e - T0;
    opens = (ds < kend);
    x.edge_no = e;
    for (int i = 0; i < NR; i++) x.rst[i] = (e < (i + 1) * RS);
    if (k < 0) begin
      x.cyc = 0; x.act = 0; x.on = 0; x.off = 0; x.fin = 0; x.code = 0;
    end else begin
      x.cyc  = (k < kend) ? k : kend;
      x.act  = opens && (k >= ds) && (k < kend);
      x.on   = opens && (k == ds);
      x.off  = opens && (k == kend);
      x.fin  = (k >= kend);
      x.code = x.fin ? kcode : 0;
    end
    return x;
  endfunction

  task automatic chk_reset(string name);
    total++;
    if (rst_out !== '1 || cycle !== '0 || dump_active !== 1'b0 || dump_on !== 1'b0 ||
        dump_off !== 1'b0 || finish !== 1'b0 || finish_code !== 2'd0) begin
      bad++;
      $display("FAIL %s reset: got rst=%b cyc=%0d act=%b on=%b off=%b fin=%b code=%0d want all-ones/zeros",
               name, rst_out, cycle, dump_active, dump_on, dump_off, finish, finish_code);
    end else begin
      $display("ok   %s reset values", name);
    end
  endtask

  task automatic setup(int a_ds, int a_de, int a_to, int a_klen);
    ds = a_ds; de = a_de; to = a_to; klen = a_klen;
    for (int k = 1; k <= 64; k++) begin cm[k] = 0; st[k] = 0; end
  endtask

  // abort_at >= 0: assert reset mid-cycle while cycle == abort_at.
  task automatic run_scn(string name, int abort_at);
    int n, k;
    cur_name = name;
    model_end();
    reset = 1'b1;
    dump_start = CW'(ds);
    dump_end   = CW'(de);
    timeout    = WW'(to);
    @(negedge clock);
    chk_reset(name);
    n = (abort_at >= 0) ? T0 + abort_at : T0 + kend + 3;
    for (int e = 1; e <= n; e++) q.push_back(exp_at(e));
    reset = 1'b0;
    for (int e = 1; e <= n; e++) begin
      k = e - T0;
      if (k >= 1 && k <= klen) begin
        commit_valid = cm[k];
        stop_req     = st[k];
      end else begin
        commit_valid = 1'($urandom_range(0, 1));
        stop_req     = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
    end
    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s drain: got %0d pending want 0", name, q.size());
      q.delete();
    end
    if (abort_at >= 0) begin
      #2 reset = 1'b1;
      #1 chk_reset({name, "_async"});
    end
    commit_valid = 1'b0;
    stop_req     = 1'b0;
  endtask

  initial begin
    // Staggered release, dump window 5..8, end by dump_end at 9.
    setup(5, 9, 0, 20);
    for (int k = 1; k <= 20; k++) cm[k] = 1;
    st[20] = 1;
    run_scn("stagger_dump", -1);

    // Window open on RUN entry, watchdog expiry after 3 idle edges.
    setup(0, 0, 3, 20);
    st[20] = 1;
    run_scn("timeout_win0", -1);

    // Commits every 2nd cycle keep the watchdog quiet; stop at 21.
    setup(40, 0, 3, 21);
    for (int k = 1; k <= 21; k++) cm[k] = (k % 2 == 0);
    st[21] = 1;
    run_scn("commit_stop", -1);

    // All three causes plus window-open on one edge.
    setup(3, 3, 3, 3);
    st[3] = 1;
    run_scn("collision", -1);

    // Reset mid-run at cycle 6, then the identical run replays.
    setup(5, 9, 0, 20);
    for (int k = 1; k <= 20; k++) cm[k] = 1;
    st[20] = 1;
    run_scn("abort", 6);
    run_scn("replay", -1);

    // dump_end before dump_start: run ends without opening the window.
    setup(8, 4, 0, 10);
    for (int k = 1; k <= 10; k++) cm[k] = 1;
    st[10] = 1;
    run_scn("end_first", -1);

    for (int r = 0; r < 12; r++) begin
      setup($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20),
            $urandom_range(0, 6), $urandom_range(5, 30));
      for (int k = 1; k <= klen; k++) begin
        cm[k] = ($urandom_range(0, 99) < 60);
        st[k] = ($urandom_range(0, 99) < 4);
      end
      st[klen] = 1;
      run_scn($sformatf("rand%0d", r), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench time limit");
  end
endmodule
